dwt_level_sched: RTL

Scheduler for the multi-level 1-D integer wavelet (lifting) datapath that sits behind the even/odd sample splitter. It sequences in-place Mallat decomposition over a line held in sample memory:
- issues read addresses with even/odd phase and boundary flags to the split/lift datapath;
- places returned low/high coefficient pairs at low-half/high-half write addresses;
- repeats on the low half for each configured level.

It sits between the line-buffer control and the lift datapath, and controls only; it carries no sample data.

---
 rtl/wavelet_pkg.sv | 20 ++
 rtl/dwt_addr_cnt.sv | 55 +++++
 rtl/dwt_level_sched.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/wavelet_pkg.sv
// Shared types and defaults for the 1-D lifting wavelet blocks.
// Phase constants are also used by the even/odd splitter.
package wavelet_pkg;

    localparam int ADDR_W     = 10;
    localparam int MAX_LEVELS = 4;
    localparam int LVL_W      = 3;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        NEXT,
        DONE
    } state_e;

endpackage

// File: rtl/dwt_addr_cnt.sv
// Read/write index counter pair for one decomposition level.
// Terminal compares run against cur_len and cur_len/2.
module dwt_addr_cnt #(
    parameter int ADDR_W = wavelet_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              rd_inc,
    input  logic              wr_inc,
    input  logic [ADDR_W:0]   cur_len,
    output logic [ADDR_W-1:0] rd_idx,
    output logic [ADDR_W-1:0] wr_idx,
    output logic              rd_tc,
    output logic              wr_full,
    output logic              wr_last
);

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
    logic [ADDR_W:0]   half;

    assign half = cur_len >> 1;

    always_comb begin
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        if (clr) begin
            rd_idx_d = '0;
            wr_idx_d = '0;
        end else begin
            if (rd_inc) rd_idx_d = rd_idx_q + 1'b1;
            if (wr_inc) wr_idx_d = wr_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx_q <= '0;
            wr_idx_q <= '0;
        end else begin
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
        end
    end

    assign rd_idx  = rd_idx_q;
    assign wr_idx  = wr_idx_q;
    assign rd_tc   = ({1'b0, rd_idx_q} == (cur_len - ONE));
    assign wr_full = ({1'b0, wr_idx_q} == half);
    assign wr_last = ({1'b0, wr_idx_q} == (half - ONE));

endmodule

// File: rtl/dwt_level_sched.sv
// Multi-level in-place Mallat scheduler for the lifting datapath.
// Issues sample reads and low/high write addresses; carries no data.
module dwt_level_sched #(
    parameter int ADDR_W     = wavelet_pkg::ADDR_W,
    parameter int MAX_LEVELS = wavelet_pkg::MAX_LEVELS,
    parameter int LVL_W      = wavelet_pkg::LVL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [LVL_W-1:0]  levels,
    input  logic              dp_ready,
    input  logic              dp_out_valid,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              phase,
    output logic              first,
    output logic              last,
    output logic [LVL_W-1:0]  level,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_lo_addr,
    output logic [ADDR_W-1:0] wr_hi_addr,
    output logic              done,
    output logic              err
);

    import wavelet_pkg::*;

    localparam logic [ADDR_W:0]  MIN_LEN = {{(ADDR_W-1){1'b0}}, 2'b10};
    localparam logic [ADDR_W:0]  MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(MAX_LEVELS);
    localparam logic [LVL_W-1:0] LVL_ONE = {{(LVL_W-1){1'b0}}, 1'b1};

    state_e state_q, state_d, lvl_end;

    logic [ADDR_W:0]   cur_len_q, cur_len_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [LVL_W-1:0]  levels_q, levels_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] rd_idx, wr_idx;
    logic              rd_tc, wr_full, wr_last;
    logic              cnt_clr, wr_ok, wr_done, cfg_ok;
    logic [ADDR_W:0]   lvl_mask;

    dwt_addr_cnt #(
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .rd_inc  (rd_en),
        .wr_inc  (wr_en),
        .cur_len (cur_len_q),
        .rd_idx  (rd_idx),
        .wr_idx  (wr_idx),
        .rd_tc   (rd_tc),
        .wr_full (wr_full),
        .wr_last (wr_last)
    );

    // Length must split evenly through every requested level.
    assign lvl_mask = ~({(ADDR_W+1){1'b1}} << levels);
    assign cfg_ok   = (levels != '0) && (levels <= MAX_LVL) &&
                      (len >= MIN_LEN) && (len <= MAX_LEN) &&
                      ((len & lvl_mask) == '0);

    assign rd_en   = (state_q == READ) & dp_ready;
    assign wr_ok   = (state_q == READ) | (state_q == DRAIN);
    assign wr_en   = dp_out_valid & wr_ok & ~wr_full;
    assign wr_done = (wr_en & wr_last) | wr_full;
    assign lvl_end = (level_q == levels_q - LVL_ONE) ? DONE : NEXT;

    always_comb begin
        state_d   = state_q;
        cur_len_d = cur_len_q;
        level_d   = level_q;
        levels_d  = levels_q;
        cnt_clr   = 1'b0;
        err_d     = dp_out_valid & ~wr_en;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_d   = READ;
                        cur_len_d = len;
                        level_d   = '0;
                        levels_d  = levels;
                        cnt_clr   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (rd_en && rd_tc) state_d = wr_done ? lvl_end : DRAIN;
            end
            DRAIN: begin
                if (wr_done) state_d = lvl_end;
            end
            NEXT: begin
                state_d   = READ;
                cur_len_d = cur_len_q >> 1;
                level_d   = level_q + LVL_ONE;
                cnt_clr   = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_len_q <= '0;
            level_q   <= '0;
            levels_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_len_q <= cur_len_d;
            level_q   <= level_d;
            levels_q  <= levels_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign level      = level_q;
    assign rd_addr    = rd_idx;
    assign phase      = (rd_idx[0] == ODD);
    assign first      = rd_en & (rd_idx == '0);
    assign last       = rd_en & rd_tc;
    assign wr_lo_addr = wr_idx;
    assign wr_hi_addr = ADDR_W'((cur_len_q >> 1) + {1'b0, wr_idx});

endmodule
